// File: rtl/bram_pkg.sv
// Shared constants and types for the image BRAM read-port arbiter.
// The image is 32x32 pixels of 8 bits, addressed linearly.
package bram_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int IMG_PIX = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid/port-id shift register that tags each BRAM read with its requester
// so the return can be steered after DEPTH cycles.
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_vld,
    input  logic i_id,
    output logic o_vld,
    output logic o_id,
    output logic o_busy
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_id[0]  <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_id   = r_id[DEPTH-1];
    assign o_busy = |r_vld;

endmodule

// File: rtl/bram_rd_arbiter.sv
// Two-port read arbiter for a single BRAM read port with burst locking.
// Grants are combinational; returns are steered by a latency-matched tag pipe.
module bram_rd_arbiter
    import bram_pkg::*;
#(
    parameter int ADDR_W    = bram_pkg::ADDR_W,
    parameter int DATA_W    = bram_pkg::DATA_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              busy
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    own_e              r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;

    logic              w_keep0;
    logic              w_keep1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_addr;
    logic              w_pipe_vld;
    logic              w_pipe_id;
    logic              w_pipe_busy;

    assign w_keep0 = lock0 && (r_cnt < CNT_MAX);
    assign w_keep1 = lock1 && (r_cnt < CNT_MAX);

    // Grants are forced low while in reset so nothing enters the tag pipe.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rstn) begin
            if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                case (r_state)
                    OWN0: begin
                        w_gnt0 = w_keep0;
                        w_gnt1 = !w_keep0;
                    end
                    OWN1: begin
                        w_gnt1 = w_keep1;
                        w_gnt0 = !w_keep1;
                    end
                    default: w_gnt0 = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        w_addr = r_addr;
        if (w_gnt0) begin
            w_addr = addr0;
        end else if (w_gnt1) begin
            w_addr = addr1;
        end
    end

    // Idle cycles leave owner and count alone so a stalled burst resumes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_addr <= w_addr;
            if (w_gnt0) begin
                if (r_state == OWN0) begin
                    if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end else begin
                    r_state <= OWN0;
                    r_cnt   <= CNT_ONE;
                end
            end else if (w_gnt1) begin
                if (r_state == OWN1) begin
                    if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end else begin
                    r_state <= OWN1;
                    r_cnt   <= CNT_ONE;
                end
            end
        end
    end

    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .i_vld  (w_gnt0 | w_gnt1),
        .i_id   (w_gnt1),
        .o_vld  (w_pipe_vld),
        .o_id   (w_pipe_id),
        .o_busy (w_pipe_busy)
    );

    assign gnt0         = w_gnt0;
    assign gnt1         = w_gnt1;
    assign bram_rd_addr = w_addr;
    assign rvalid0      = w_pipe_vld & ~w_pipe_id;
    assign rvalid1      = w_pipe_vld & w_pipe_id;
    assign rdata        = bram_rd_data;
    assign busy         = w_gnt0 | w_gnt1 | w_pipe_busy;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench driving RD_LAT=1 and RD_LAT=3 arbiters in lockstep,
// with per-instance return scoreboards.
module tb_bram_rd_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MB = 32;

    typedef struct {
        bit          port;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;

    logic          g0_1, g1_1, rv0_1, rv1_1, busy_1;
    logic [DW-1:0] rdata_1, bdat_1;
    logic [AW-1:0] baddr_1;

    logic          g0_3, g1_3, rv0_3, rv1_3, busy_3;
    logic [DW-1:0] rdata_3, bdat_3;
    logic [AW-1:0] baddr_3;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] p3 [3];

    exp_t          q1[$];
    exp_t          q3[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            a0 = 0;
    int            a1 = 512;
    logic [AW-1:0] exp_addr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_rd_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(MB)
    ) u_dut1 (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(g0_1), .gnt1(g1_1), .rvalid0(rv0_1), .rvalid1(rv1_1),
        .rdata(rdata_1), .bram_rd_addr(baddr_1), .bram_rd_data(bdat_1),
        .busy(busy_1)
    );

    bram_rd_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_BURST(MB)
    ) u_dut3 (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(g0_3), .gnt1(g1_3), .rvalid0(rv0_3), .rvalid1(rv1_3),
        .rdata(rdata_3), .bram_rd_addr(baddr_3), .bram_rd_data(bdat_3),
        .busy(busy_3)
    );

    function automatic logic [DW-1:0] memf(input int a);
        int v;
        v = (a * 37 + 11) ^ (a >>> 3);
        return v[DW-1:0];
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = memf(i);
    end

    always @(posedge clk) bdat_1 <= mem[baddr_1];

    always @(posedge clk) begin
        p3[0] <= mem[baddr_3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bdat_3 = p3[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        #2;
        if (q1.size() > 0 && q1[0].cyc < cyc) begin
            e = q1.pop_front();
            chk("rv_missing_L1", 32'(e.cyc), 32'(cyc));
        end
        if (rv0_1 || rv1_1) begin
            chk("rv_onehot_L1", 32'(rv0_1 & rv1_1), 32'(0));
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rv_unexpected_L1: rv0=%0b rv1=%0b, none expected (cycle %0d)",
                         rv0_1, rv1_1, cyc);
            end else begin
                e = q1.pop_front();
                chk("rv_port_L1", 32'(rv1_1), 32'(e.port));
                chk("rdata_L1", 32'(rdata_1), 32'(e.data));
                chk("rv_cycle_L1", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        #2;
        if (q3.size() > 0 && q3[0].cyc < cyc) begin
            e = q3.pop_front();
            chk("rv_missing_L3", 32'(e.cyc), 32'(cyc));
        end
        if (rv0_3 || rv1_3) begin
            chk("rv_onehot_L3", 32'(rv0_3 & rv1_3), 32'(0));
            if (q3.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rv_unexpected_L3: rv0=%0b rv1=%0b, none expected (cycle %0d)",
                         rv0_3, rv1_3, cyc);
            end else begin
                e = q3.pop_front();
                chk("rv_port_L3", 32'(rv1_3), 32'(e.port));
                chk("rdata_L3", 32'(rdata_3), 32'(e.data));
                chk("rv_cycle_L3", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // eg: expected grant, 0 or 1, or -1 for no grant
    task automatic step(input bit r0, input bit r1, input bit l0,
                        input bit l1, input int eg);
        bit e0, e1;
        @(negedge clk);
        rstn  = 1'b1;
        req0  = r0;
        req1  = r1;
        lock0 = l0;
        lock1 = l1;
        addr0 = AW'(a0);
        addr1 = AW'(a1);
        #1;
        e0 = (eg == 0);
        e1 = (eg == 1);
        if (e0) exp_addr = addr0;
        else if (e1) exp_addr = addr1;
        chk("gnt0_L1", 32'(g0_1), 32'(e0));
        chk("gnt1_L1", 32'(g1_1), 32'(e1));
        chk("gnt0_L3", 32'(g0_3), 32'(e0));
        chk("gnt1_L3", 32'(g1_3), 32'(e1));
        chk("addr_L1", 32'(baddr_1), 32'(exp_addr));
        chk("addr_L3", 32'(baddr_3), 32'(exp_addr));
        if (e0 || e1) begin
            chk("busy_gnt_L1", 32'(busy_1), 32'(1));
            chk("busy_gnt_L3", 32'(busy_3), 32'(1));
            q1.push_back(exp_t'{port: e1, data: memf(int'(exp_addr)), cyc: cyc + 1});
            q3.push_back(exp_t'{port: e1, data: memf(int'(exp_addr)), cyc: cyc + 3});
        end
        a0 = (a0 + 1) % (1 << AW);
        a1 = (a1 + 1) % (1 << AW);
    endtask

    task automatic run(input int n, input bit r0, input bit r1,
                       input bit l0, input bit l1, input int eg);
        repeat (n) step(r0, r1, l0, l1, eg);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt0"}, 32'({g0_1, g0_3}), 32'(0));
        chk({tag, "_gnt1"}, 32'({g1_1, g1_3}), 32'(0));
        chk({tag, "_rvalid"}, 32'({rv0_1, rv1_1, rv0_3, rv1_3}), 32'(0));
        chk({tag, "_busy"}, 32'({busy_1, busy_3}), 32'(0));
        chk({tag, "_addr_L1"}, 32'(baddr_1), 32'(0));
        chk({tag, "_addr_L3"}, 32'(baddr_3), 32'(0));
    endtask

    // Reset is held for one cycle; the next step() releases it.
    task automatic do_reset();
        @(negedge clk);
        rstn  = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        lock0 = 1'b0;
        lock1 = 1'b0;
        q1.delete();
        q3.delete();
        exp_addr = '0;
        #1;
        chk_quiet("rst_a");
        @(posedge clk);
        #1;
        chk_quiet("rst_b");
    endtask

    initial begin
        rstn  = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        lock0 = 1'b0;
        lock1 = 1'b0;
        addr0 = '0;
        addr1 = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // port 0 alone, addresses 0..9
        run(10, 1, 0, 0, 0, 0);
        run(4, 0, 0, 0, 0, -1);
        chk("drained_busy_L1", 32'(busy_1), 32'(0));
        chk("drained_busy_L3", 32'(busy_3), 32'(0));

        // contention from OWN0 without lock: other port first
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);

        // reset with reads in flight, then contention from IDLE
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, i % 2);

        // locked burst of port 0 capped at MAX_BURST
        run(MB, 1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 0);

        // stall inside a locked burst keeps the count
        run(27, 1, 1, 1, 0, 0);
        run(2, 0, 0, 1, 0, -1);
        run(4, 1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);

        // lone requester is granted past saturation
        run(40, 0, 1, 0, 0, 1);
        run(3, 1, 0, 0, 0, 0);

        // port 1 locked burst, then release
        run(4, 1, 1, 0, 1, 1);
        step(1, 1, 0, 0, 0);

        run(6, 0, 0, 0, 0, -1);
        chk("final_busy_L1", 32'(busy_1), 32'(0));
        chk("final_busy_L3", 32'(busy_3), 32'(0));
        chk("final_q_L1", 32'(q1.size()), 32'(0));
        chk("final_q_L3", 32'(q3.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_rd_arbiter.md
BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, BRAM read address width (32x32 image).
REQ-002 SHALL have parameter DATA_W, default 8, pixel width.
REQ-003 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles (address to data), legal range 1..3.
REQ-004 SHALL have parameter MAX_BURST, default 32, maximum consecutive grants to one requester while the other waits.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports req0 / req1  input  1  read request from port 0 (detection core) / port 1 (UART readback).
REQ-008 SHALL have ports addr0 / addr1  input  ADDR_W  read address, valid while reqN high.
REQ-009 SHALL have ports lock0 / lock1  input  1  burst hold request (e.g. row scan).
REQ-010 SHALL have ports gnt0 / gnt1  output  1  address accepted this cycle.
REQ-011 SHALL have ports rvalid0 / rvalid1  output  1  read data for that port valid this cycle.
REQ-012 SHALL have port rdata  output  DATA_W  read data, shared by both ports, qualified by rvalidN.
REQ-013 SHALL have port bram_rd_addr  output  ADDR_W  address to BRAM read port.
REQ-014 SHALL have port bram_rd_data  input  DATA_W  data from BRAM read port.
REQ-015 SHALL have port busy  output  1  any grant this cycle or any read in flight.

Function
REQ-016 SHALL keep a state register: IDLE (no owner yet), OWN0, OWN1 (last granted port).
REQ-017 SHALL grant combinationally in the request cycle: a transfer occurs when reqN and gntN are high in the same cycle.
REQ-018 SHALL assert at most one gnt per cycle; gntN never high without reqN.
REQ-019 Single requester SHALL be granted every cycle it requests, regardless of state or burst count.
REQ-020 Both requesting, state IDLE: SHALL grant port 0.
REQ-021 Both requesting, state OWNn: SHALL grant port n again if lockn high and burst_cnt < MAX_BURST; otherwise SHALL grant the other port.
REQ-022 burst_cnt SHALL count consecutive grants to the same port: set to 1 on owner change, incremented on repeat grant, saturating at MAX_BURST.
REQ-023 Cycle with no grant SHALL leave state and burst_cnt unchanged (idle cycles do not break a burst).
REQ-024 bram_rd_addr SHALL equal the granted port's address in the grant cycle; with no grant it SHALL hold its last registered value.
REQ-025 rvalidN SHALL assert exactly RD_LAT cycles after a gntN cycle, for one cycle per grant; back-to-back grants give back-to-back rvalids, in grant order.
REQ-026 rdata SHALL pass bram_rd_data through unregistered.
REQ-027 Port ID SHALL travel with each read through an RD_LAT-deep valid/id pipeline; ownership change SHALL not corrupt in-flight returns.
REQ-028 busy SHALL be high when gnt0|gnt1 or any pipeline stage holds a valid entry.

Reset
REQ-029 While rstn low: state IDLE, burst_cnt 0, pipeline cleared, gnt0/gnt1 0, rvalid0/rvalid1 0, busy 0, bram_rd_addr 0.
REQ-030 Reset asserted mid-burst SHALL drop all in-flight reads; no rvalid SHALL appear for them after release.
REQ-031 First cycle after release SHALL arbitrate as IDLE.

Structure
REQ-032 Package bram_pkg SHALL hold ADDR_W, DATA_W, image dimension constants (32x32), and the owner state enum (IDLE, OWN0, OWN1).
REQ-033 Sub-module rd_lat_pipe SHALL implement the RD_LAT-deep valid/port-id shift register; the arbitration FSM stays in bram_rd_arbiter.

Verification
REQ-034 req0 only, addr0=0..9 consecutively, RD_LAT=1 -> gnt0 10 cycles, rvalid0 10 cycles starting one cycle later, rdata = memory model[0..9], rvalid1 never high.
REQ-035 req0 and req1 continuously, lock low -> grants alternate 0,1,0,1 starting with port 0 from IDLE.
REQ-036 req0+lock0 held, req1 held, MAX_BURST=32 -> 32 consecutive gnt0, then one gnt1, then port 0 again if lock0 still high.
REQ-037 RD_LAT=3, alternating grants -> each rvalidN 3 cycles after its gntN, data tagged to correct port, no drops or duplicates.
REQ-038 rstn pulsed low for 1 cycle after 5 grants with reads in flight -> rvalid0/rvalid1 low immediately and stay low until new grants; first post-reset contention grants port 0.
REQ-039 req0 stalls 2 cycles inside a locked burst (req1 low) -> burst_cnt unchanged, burst continues counting on resume.
